// File: rtl/chunk_serial_subtractor_pkg.sv
// -----------------------------------------------------------------------------
// sub_pkg
//   Shared definitions for chunk_serial_subtractor:
//     - state_e      : FSM state encoding (IDLE, CALC, DONE)
//     - cfg_ok()     : WIDTH must be a positive multiple of CHUNK
//     - num_chunks() : N = WIDTH / CHUNK chunk cycles per operation
//     - idx_bits()   : width of the chunk index counter (at least 1 bit)
// -----------------------------------------------------------------------------
package sub_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_e;

   function automatic bit cfg_ok(input int width, input int chunk);
      return (chunk > 0) && (width >= chunk) && ((width % chunk) == 0);
   endfunction

   function automatic int num_chunks(input int width, input int chunk);
      return width / chunk;
   endfunction

   // With a single chunk the counter is never advanced, but a zero-width
   // vector is not legal, so keep one bit.
   function automatic int idx_bits(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage : sub_pkg

// File: rtl/chunk_serial_subtractor_if.sv
// -----------------------------------------------------------------------------
// chunk_serial_subtractor_if
//   Operand and result handshakes of the chunk-serial subtractor.
//
//   Handshake rule (both channels): a transfer happens on the rising clock
//   edge where valid and ready are both 1. The producer keeps valid and its
//   payload stable until that edge; ready never depends combinationally on
//   valid in this block.
//
//   Signals:
//     in_valid  master->slave  operands present
//     in_ready  slave->master  block can accept operands
//     a, b      master->slave  minuend / subtrahend (WIDTH)
//     bin       master->slave  borrow-in
//     out_valid slave->master  result present
//     out_ready master->slave  consumer accepts result
//     d         slave->master  difference (WIDTH)
//     bout      slave->master  borrow-out of MSB
//     ovf       slave->master  signed overflow
//     zero      slave->master  d == 0
// -----------------------------------------------------------------------------
interface chunk_serial_subtractor_if #(
   parameter int WIDTH = 16
) ();

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             bin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] d;
   logic             bout;
   logic             ovf;
   logic             zero;

   modport master (
      output in_valid, a, b, bin, out_ready,
      input  in_ready, out_valid, d, bout, ovf, zero
   );

   modport slave (
      input  in_valid, a, b, bin, out_ready,
      output in_ready, out_valid, d, bout, ovf, zero
   );

endinterface : chunk_serial_subtractor_if

// File: rtl/chunk_serial_subtractor_sub_chunk.sv
// -----------------------------------------------------------------------------
// sub_chunk
//   Combinational CHUNK-bit ripple-borrow subtractor: d = a - b - bin.
//   Ports:
//     a_i, b_i   CHUNK-bit operands
//     bin_i      borrow into bit 0
//     d_o        CHUNK-bit difference
//     bout_o     borrow out of the top bit
//     bmsb_o     borrow into the top bit (for signed-overflow detection)
// -----------------------------------------------------------------------------
module sub_chunk #(
   parameter int CHUNK = 4
) (
   input  logic [CHUNK-1:0] a_i,
   input  logic [CHUNK-1:0] b_i,
   input  logic             bin_i,
   output logic [CHUNK-1:0] d_o,
   output logic             bout_o,
   output logic             bmsb_o
);

   // br[i] is the borrow into bit i; br[CHUNK] leaves the chunk.
   logic [CHUNK:0] br;

   always_comb begin
      br    = '0;
      d_o   = '0;
      br[0] = bin_i;
      for (int i = 0; i < CHUNK; i++) begin
         d_o[i]   = a_i[i] ^ b_i[i] ^ br[i];
         // Borrow when a<b at this bit, or when they are equal and a borrow
         // is already pending from below.
         br[i+1]  = (~a_i[i] & b_i[i]) | (~(a_i[i] ^ b_i[i]) & br[i]);
      end
   end

   assign bout_o = br[CHUNK];
   assign bmsb_o = br[CHUNK-1];

endmodule : sub_chunk

// File: rtl/chunk_serial_subtractor.sv
// -----------------------------------------------------------------------------
// chunk_serial_subtractor
//   Multi-cycle subtractor D = A - B - bin over WIDTH bits, CHUNK bits per
//   clock. The borrow between chunks is held in a register, so one CHUNK-bit
//   subtractor is reused N = WIDTH/CHUNK times per operation.
//
//   Ports:
//     clk          rising-edge clock
//     rst_n        asynchronous active-low reset
//     bus          operand/result handshakes (chunk_serial_subtractor_if.slave)
//     dbg_state_o  current FSM state
//
//   Timing: operands accepted at edge k -> out_valid high after edge k+N.
//   Result is held in DONE until out_ready; back to IDLE one edge later.
// -----------------------------------------------------------------------------
module chunk_serial_subtractor
   import sub_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   chunk_serial_subtractor_if.slave   bus,
   output state_e                     dbg_state_o
);

   localparam int N     = num_chunks(WIDTH, CHUNK);
   localparam int IDX_W = idx_bits(N);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

   if (!cfg_ok(WIDTH, CHUNK)) begin : g_bad_cfg
      $error("chunk_serial_subtractor: WIDTH must be a positive multiple of CHUNK");
   end

   // ---------------------------------------------------------------------------
   // State and datapath registers
   // ---------------------------------------------------------------------------
   state_e             state_q,  state_d;
   logic [WIDTH-1:0]   a_q,      a_d;
   logic [WIDTH-1:0]   b_q,      b_d;
   logic [WIDTH-1:0]   d_q,      d_d;
   logic               borrow_q, borrow_d;
   logic [IDX_W-1:0]   idx_q,    idx_d;
   logic               ovf_q,    ovf_d;
   logic               zero_q,   zero_d;

   // ---------------------------------------------------------------------------
   // Chunk datapath
   // ---------------------------------------------------------------------------
   logic [CHUNK-1:0]   chunk_a;
   logic [CHUNK-1:0]   chunk_b;
   logic [CHUNK-1:0]   chunk_d;
   logic               chunk_bout;
   logic               chunk_bmsb;
   logic [WIDTH-1:0]   d_next;
   int                 base;

   assign base    = int'(idx_q) * CHUNK;
   assign chunk_a = a_q[base +: CHUNK];
   assign chunk_b = b_q[base +: CHUNK];

   sub_chunk #(
      .CHUNK (CHUNK)
   ) u_chunk (
      .a_i    (chunk_a),
      .b_i    (chunk_b),
      .bin_i  (borrow_q),
      .d_o    (chunk_d),
      .bout_o (chunk_bout),
      .bmsb_o (chunk_bmsb)
   );

   // Result with the current chunk merged in; on the last chunk this is the
   // complete difference, which lets zero be registered on entry to DONE.
   always_comb begin
      d_next              = d_q;
      d_next[base +: CHUNK] = chunk_d;
   end

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      d_d      = d_q;
      borrow_d = borrow_q;
      idx_d    = idx_q;
      ovf_d    = ovf_q;
      zero_d   = zero_q;

      unique case (state_q)
         IDLE: begin
            // in_ready is 1 throughout IDLE, so in_valid alone is the transfer.
            if (bus.in_valid) begin
               a_d      = bus.a;
               b_d      = bus.b;
               borrow_d = bus.bin;
               idx_d    = '0;
               state_d  = CALC;
            end
         end

         CALC: begin
            d_d      = d_next;
            borrow_d = chunk_bout;
            if (idx_q == LAST_IDX) begin
               // Signed overflow: borrow into the MSB differs from the borrow
               // out of it.
               ovf_d   = chunk_bmsb ^ chunk_bout;
               zero_d  = (d_next == '0);
               state_d = DONE;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end

         DONE: begin
            if (bus.out_ready) begin
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         a_q      <= '0;
         b_q      <= '0;
         d_q      <= '0;
         borrow_q <= 1'b0;
         idx_q    <= '0;
         ovf_q    <= 1'b0;
         zero_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         d_q      <= d_d;
         borrow_q <= borrow_d;
         idx_q    <= idx_d;
         ovf_q    <= ovf_d;
         zero_q   <= zero_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs: all driven from registers, so neither ready nor valid has a
   // combinational path from the opposite side of the handshake.
   // ---------------------------------------------------------------------------
   assign bus.in_ready  = (state_q == IDLE);
   assign bus.out_valid = (state_q == DONE);
   assign bus.d         = d_q;
   assign bus.bout      = borrow_q;
   assign bus.ovf       = ovf_q;
   assign bus.zero      = zero_q;
   assign dbg_state_o   = state_q;

endmodule : chunk_serial_subtractor

// File: tb/tb_chunk_serial_subtractor.sv
// -----------------------------------------------------------------------------
// tb_chunk_serial_subtractor
//   Three instances (CHUNK = 1, 4, 16; WIDTH = 16) driven with identical
//   stimulus. Directed vectors carry hand-computed results; the random sweep
//   uses an arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_chunk_serial_subtractor;
   import sub_pkg::*;

   localparam int W = 16;
   localparam int LAT_EXP [3] = '{16, 4, 1};

   // ---------------------------------------------------------------------------
   // Clock / reset
   // ---------------------------------------------------------------------------
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // ---------------------------------------------------------------------------
   // DUTs
   // ---------------------------------------------------------------------------
   chunk_serial_subtractor_if #(.WIDTH(W)) bus1  ();
   chunk_serial_subtractor_if #(.WIDTH(W)) bus4  ();
   chunk_serial_subtractor_if #(.WIDTH(W)) bus16 ();

   state_e st [3];

   chunk_serial_subtractor #(.WIDTH(W), .CHUNK(1)) u_dut1 (
      .clk (clk), .rst_n (rst_n), .bus (bus1), .dbg_state_o (st[0])
   );
   chunk_serial_subtractor #(.WIDTH(W), .CHUNK(4)) u_dut4 (
      .clk (clk), .rst_n (rst_n), .bus (bus4), .dbg_state_o (st[1])
   );
   chunk_serial_subtractor #(.WIDTH(W), .CHUNK(16)) u_dut16 (
      .clk (clk), .rst_n (rst_n), .bus (bus16), .dbg_state_o (st[2])
   );

   logic         ov [3];
   logic         ir [3];
   logic [W-1:0] dd [3];
   logic         bo [3];
   logic         of [3];
   logic         zr [3];

   assign ov[0] = bus1.out_valid;  assign ov[1] = bus4.out_valid;  assign ov[2] = bus16.out_valid;
   assign ir[0] = bus1.in_ready;   assign ir[1] = bus4.in_ready;   assign ir[2] = bus16.in_ready;
   assign dd[0] = bus1.d;          assign dd[1] = bus4.d;          assign dd[2] = bus16.d;
   assign bo[0] = bus1.bout;       assign bo[1] = bus4.bout;       assign bo[2] = bus16.bout;
   assign of[0] = bus1.ovf;        assign of[1] = bus4.ovf;        assign of[2] = bus16.ovf;
   assign zr[0] = bus1.zero;       assign zr[1] = bus4.zero;       assign zr[2] = bus16.zero;

   // ---------------------------------------------------------------------------
   // Checker
   // ---------------------------------------------------------------------------
   task automatic chk(input string tag, input int i,
                      input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s[chunk_inst=%0d] observed=%0h expected=%0h", tag, i, obs, exp);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Driver tasks
   // ---------------------------------------------------------------------------
   task automatic drive_in(input logic v, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic bin);
      bus1.in_valid  = v; bus1.a  = a; bus1.b  = b; bus1.bin  = bin;
      bus4.in_valid  = v; bus4.a  = a; bus4.b  = b; bus4.bin  = bin;
      bus16.in_valid = v; bus16.a = a; bus16.b = b; bus16.bin = bin;
   endtask

   task automatic drive_out_ready(input logic r);
      bus1.out_ready  = r;
      bus4.out_ready  = r;
      bus16.out_ready = r;
   endtask

   task automatic check_reset(input string tag);
      for (int i = 0; i < 3; i++) begin
         chk({tag, "_in_ready"},  i, ir[i], 1);
         chk({tag, "_out_valid"}, i, ov[i], 0);
         chk({tag, "_d"},         i, dd[i], 0);
         chk({tag, "_bout"},      i, bo[i], 0);
         chk({tag, "_ovf"},       i, of[i], 0);
         chk({tag, "_zero"},      i, zr[i], 0);
         chk({tag, "_state"},     i, st[i], 32'(IDLE));
      end
   endtask

   // Present operands for exactly one edge, then scramble the inputs so a
   // design that keeps reading them would be caught.
   task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
      for (int i = 0; i < 3; i++) chk("in_ready_before_accept", i, ir[i], 1);
      drive_in(1'b1, a, b, bin);
      @(posedge clk); #1;
      drive_in(1'b0, W'($urandom_range(0, 65535)), W'($urandom_range(0, 65535)),
               1'($urandom_range(0, 1)));
   endtask

   task automatic wait_done();
      int lat [3];
      lat = '{0, 0, 0};
      for (int c = 1; c <= 40; c++) begin
         @(posedge clk); #1;
         for (int i = 0; i < 3; i++) if (lat[i] == 0 && ov[i]) lat[i] = c;
         if (lat[0] != 0 && lat[1] != 0 && lat[2] != 0) break;
      end
      for (int i = 0; i < 3; i++) chk("latency", i, lat[i], LAT_EXP[i]);
   endtask

   task automatic check_result(input string tag, input logic [W-1:0] ed,
                               input logic eb, input logic eo, input logic ez);
      for (int i = 0; i < 3; i++) begin
         chk({tag, "_out_valid"}, i, ov[i], 1);
         chk({tag, "_in_ready"},  i, ir[i], 0);
         chk({tag, "_d"},         i, dd[i], ed);
         chk({tag, "_bout"},      i, bo[i], eb);
         chk({tag, "_ovf"},       i, of[i], eo);
         chk({tag, "_zero"},      i, zr[i], ez);
      end
   endtask

   task automatic release_out();
      drive_out_ready(1'b1);
      @(posedge clk); #1;
      drive_out_ready(1'b0);
      for (int i = 0; i < 3; i++) begin
         chk("after_release_out_valid", i, ov[i], 0);
         chk("after_release_in_ready",  i, ir[i], 1);
      end
   endtask

   task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic bin, input logic [W-1:0] ed, input logic eb,
                         input logic eo, input logic ez);
      start_op(a, b, bin);
      wait_done();
      check_result(tag, ed, eb, eo, ez);
      release_out();
   endtask

   // Reference: unsigned wide subtraction for d/bout, integer range test
   // for signed overflow.
   task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                        output logic [W-1:0] ed, output logic eb,
                        output logic eo, output logic ez);
      logic [W:0] full;
      int         sr;
      full = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
      ed   = full[W-1:0];
      eb   = full[W];
      sr   = int'($signed(a)) - int'($signed(b)) - int'(bin);
      eo   = (sr > 32767) || (sr < -32768);
      ez   = (ed == '0);
   endtask

   // ---------------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------------
   initial begin
      logic [W-1:0] ra, rb, ed;
      logic         rbin, eb, eo, ez;

      rst_n = 1'b0;
      drive_in(1'b0, '0, '0, 1'b0);
      drive_out_ready(1'b0);
      #12;
      check_reset("por");
      #1 rst_n = 1'b1;
      @(posedge clk); #1;

      // Directed vectors
      run_op("basic",     16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0);
      run_op("underflow", 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0);
      run_op("sovf",      16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0);
      run_op("zero_bin",  16'h5555, 16'h5554, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1);

      // Backpressure: result must hold while in_valid pulses are ignored
      start_op(16'h1234, 16'h1111, 1'b0);
      wait_done();
      check_result("bp_first", 16'h0123, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 5; k++) begin
         drive_in(1'b1, 16'hFFFF, 16'h0000, 1'b1);
         @(posedge clk); #1;
         check_result("bp_hold", 16'h0123, 1'b0, 1'b0, 1'b0);
      end
      drive_in(1'b0, '0, '0, 1'b0);
      release_out();

      // Reset during the second CALC cycle of the CHUNK=4 instance
      start_op(16'h1234, 16'h0234, 1'b0);
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      check_reset("mid_calc_reset");
      #2 rst_n = 1'b1;
      @(posedge clk); #1;
      check_reset("after_reset_release");
      run_op("post_reset", 16'h00FF, 16'h000F, 1'b0, 16'h00F0, 1'b0, 1'b0, 1'b0);

      // Random sweep against the reference model
      for (int n = 0; n < 1000; n++) begin
         ra   = W'($urandom_range(0, 65535));
         rb   = W'($urandom_range(0, 65535));
         rbin = 1'($urandom_range(0, 1));
         model(ra, rb, rbin, ed, eb, eo, ez);
         run_op("random", ra, rb, rbin, ed, eb, eo, ez);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule : tb_chunk_serial_subtractor
